hyper_responder: RTL and testbench

//  HyperBus target (device side) of the HyperRAM link: decodes CA phase, honours fixed latency, serves

---
 rtl/hyper_pkg.sv | 37 +++
 rtl/hyper_resp_mem.sv | 26 ++
 rtl/hyper_responder.sv | 212 +++++++++++++++++++++
 tb/tb_hyper_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_pkg.sv
// rtl/hyper_pkg.sv - shared constants and types for the HyperBus responder
// Purpose: CA bit positions, FSM state enum, register selectors and register reset values.
// Ports: none (package).
package hyper_pkg;

  // Command/address word layout (48 bits, MSB byte first on the bus)
  localparam int CA_W       = 48;
  localparam int CA_EDGES   = CA_W / 8;
  localparam int CA_RW_BIT  = 47;   // 1 = read
  localparam int CA_AS_BIT  = 46;   // 1 = register space
  localparam int CA_BT_BIT  = 45;   // burst type, ignored: every burst is linear
  localparam int CA_UA_HI   = 44;
  localparam int CA_UA_LO   = 16;
  localparam int CA_LA_HI   = 2;

  // Word-address bit that separates ID registers (0) from config registers (1)
  localparam int REG_CR_BIT = 11;

  localparam logic [15:0] ID1_VAL = 16'h0000;
  localparam logic [15:0] CR0_RST = 16'h8F1F;
  localparam logic [15:0] CR1_RST = 16'h0002;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CA, ST_LAT, ST_RD, ST_WR, ST_REG_WR, ST_DONE
  } state_t;

  // {CR/ID select, address bit 0}
  typedef enum logic [1:0] {
    REG_ID0 = 2'b00, REG_ID1 = 2'b01, REG_CR0 = 2'b10, REG_CR1 = 2'b11
  } reg_sel_t;

  // Full 32-bit word address carried by a CA word
  function automatic logic [31:0] ca_word_addr(input logic [CA_W-1:0] ca);
    return {ca[CA_UA_HI:CA_UA_LO], ca[CA_LA_HI:0]};
  endfunction

endpackage

// File: rtl/hyper_resp_mem.sv
// rtl/hyper_resp_mem.sv - byte-writable 16-bit synchronous RAM for the responder
// Purpose: 2^ADDR_W x 16 storage, one write port with two byte enables, one registered read port.
// Ports: clk; we/be/waddr/wdata write port (be[1] = high byte); raddr in, rdata out one clk later.
module hyper_resp_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      if (be[1]) mem[waddr][15:8] <= wdata[15:8];
      if (be[0]) mem[waddr][7:0]  <= wdata[7:0];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hyper_responder.sv
// rtl/hyper_responder.sv - HyperBus target: CA decode, fixed latency, linear bursts to internal RAM
// Purpose: device side of the HyperRAM link, bus edges found by oversampling dram_ck in clk.
//   Optional macro HYPER_RESP_REG_EN: live ID0/ID1/CR0/CR1 register space; otherwise register
//   reads return 0 and register writes are discarded with unchanged timing.
// Ports: clk, reset (sync, active high); dram_ck, dram_cs_l, dram_rst_l, dram_dq_in, dram_rwds_in
//   from the controller; dram_dq_out/dram_dq_oe_l and dram_rwds_out/dram_rwds_oe_l back to it;
//   busy (not idle), proto_err (one-cycle pulse on CA phase cut short).
//   LATENCY_EDGES must be at least 1.
module hyper_responder
  import hyper_pkg::*;
#(
  parameter int          ADDR_W        = 10,
  parameter int          LATENCY_EDGES = 22,
  parameter logic        LAT2X         = 1'b1,
  parameter logic [15:0] ID0_VAL       = 16'h0C81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dram_ck,
  input  logic       dram_cs_l,
  input  logic       dram_rst_l,
  input  logic [7:0] dram_dq_in,
  output logic [7:0] dram_dq_out,
  output logic       dram_dq_oe_l,
  input  logic       dram_rwds_in,
  output logic       dram_rwds_out,
  output logic       dram_rwds_oe_l,
  output logic       busy,
  output logic       proto_err
);

  localparam int LAT_W = 8;

  state_t            state;
  logic              ck_q, cs_q;
  logic [2:0]        ca_cnt;
  logic [39:0]       ca_sr;       // first five CA bytes; sixth comes straight from dram_dq_in
  logic [LAT_W-1:0]  lat_cnt;
  logic              rd_op, reg_op;
  reg_sel_t          reg_idx;
  logic [ADDR_W-1:0] addr;
  logic              hi_next;     // next data edge carries the high byte
  logic [7:0]        wr_hi;
  logic              wr_hi_mask;

  logic              rst, edge_det, cs_fall;
  logic [CA_W-1:0]   ca_full;
  logic [31:0]       ca_waddr;
  logic [ADDR_W-1:0] addr_inc, mem_raddr;
  logic              mem_we;
  logic [15:0]       mem_rdata, reg_word, rd_word;

  assign rst      = reset | ~dram_rst_l;
  assign edge_det = (dram_ck ^ ck_q) & ~dram_cs_l;
  assign cs_fall  = cs_q & ~dram_cs_l;
  assign ca_full  = {ca_sr, dram_dq_in};
  assign ca_waddr = ca_word_addr(ca_full);
  assign addr_inc = addr + ADDR_W'(1);

  // Reads may see a data edge every clk, so the RAM is addressed with the post-increment
  // address on the low-byte edge; the next word is then ready for the following high byte.
  assign mem_raddr = (state == ST_RD && edge_det && !hi_next) ? addr_inc : addr;
  // Commit on the low-byte edge; gating with rst guarantees no write once reset hits.
  assign mem_we    = (state == ST_WR) && edge_det && !hi_next && !rst;
  assign rd_word   = reg_op ? reg_word : mem_rdata;

  logic unused_ca;
  assign unused_ca = ^{ca_full[CA_BT_BIT], ca_full[15:3], ca_waddr};

  hyper_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    ({~wr_hi_mask, ~dram_rwds_in}),
    .waddr (addr),
    .wdata ({wr_hi, dram_dq_in}),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

`ifdef HYPER_RESP_REG_EN
  logic [15:0] cr0, cr1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cr0 <= CR0_RST;
      cr1 <= CR1_RST;
    end else if (state == ST_REG_WR && edge_det && !hi_next) begin
      if (reg_idx[0]) cr1 <= {wr_hi, dram_dq_in};
      else            cr0 <= {wr_hi, dram_dq_in};
    end
  end

  always_comb begin
    reg_word = 16'h0000;
    case (reg_idx)
      REG_ID0: reg_word = ID0_VAL;
      REG_ID1: reg_word = ID1_VAL;
      REG_CR0: reg_word = cr0;
      REG_CR1: reg_word = cr1;
      default: reg_word = 16'h0000;
    endcase
  end
`else
  logic unused_reg;
  assign unused_reg = ^reg_idx;
  assign reg_word   = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    ck_q <= dram_ck;
    cs_q <= dram_cs_l;
    if (rst) begin
      state          <= ST_IDLE;
      dram_dq_out    <= 8'h00;
      dram_dq_oe_l   <= 1'b1;
      dram_rwds_out  <= 1'b0;
      dram_rwds_oe_l <= 1'b1;
      busy           <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      if (dram_cs_l) begin
        // Deselect ends any transaction; a pending lone high byte is simply dropped.
        if (state == ST_CA) proto_err <= 1'b1;
        state          <= ST_IDLE;
        dram_dq_out    <= 8'h00;
        dram_dq_oe_l   <= 1'b1;
        dram_rwds_out  <= 1'b0;
        dram_rwds_oe_l <= 1'b1;
        busy           <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state          <= ST_CA;
              ca_cnt         <= 3'd0;
              busy           <= 1'b1;
              dram_rwds_oe_l <= 1'b0;
              dram_rwds_out  <= LAT2X;
            end
          end
          ST_CA: begin
            if (edge_det) begin
              ca_sr  <= {ca_sr[31:0], dram_dq_in};
              ca_cnt <= ca_cnt + 3'd1;
              if (ca_cnt == 3'(CA_EDGES - 1)) begin
                rd_op          <= ca_full[CA_RW_BIT];
                reg_op         <= ca_full[CA_AS_BIT];
                addr           <= ca_waddr[ADDR_W-1:0];
                reg_idx        <= reg_sel_t'({ca_waddr[REG_CR_BIT], ca_waddr[0]});
                hi_next        <= 1'b1;
                lat_cnt        <= LAT_W'(LATENCY_EDGES);
                dram_rwds_oe_l <= 1'b1;
                dram_rwds_out  <= 1'b0;
                if (!ca_full[CA_RW_BIT] && ca_full[CA_AS_BIT]) state <= ST_REG_WR;
                else                                           state <= ST_LAT;
              end
            end
          end
          ST_LAT: begin
            if (edge_det) begin
              lat_cnt <= lat_cnt - LAT_W'(1);
              if (lat_cnt == LAT_W'(1)) begin
                if (rd_op) begin
                  state          <= ST_RD;
                  dram_dq_oe_l   <= 1'b0;
                  dram_rwds_oe_l <= 1'b0;
                end else begin
                  state <= ST_WR;
                end
              end
            end
          end
          ST_RD: begin
            if (edge_det) begin
              hi_next <= ~hi_next;
              if (hi_next) begin
                dram_dq_out   <= rd_word[15:8];
                dram_rwds_out <= 1'b1;
              end else begin
                dram_dq_out   <= rd_word[7:0];
                dram_rwds_out <= 1'b0;
                addr          <= addr_inc;
              end
            end
          end
          ST_WR: begin
            if (edge_det) begin
              hi_next <= ~hi_next;
              if (hi_next) begin
                wr_hi      <= dram_dq_in;
                wr_hi_mask <= dram_rwds_in;
              end else begin
                addr <= addr_inc;
              end
            end
          end
          ST_REG_WR: begin
            if (edge_det) begin
              hi_next <= ~hi_next;
              if (hi_next) wr_hi <= dram_dq_in;
              else         state <= ST_DONE;
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyper_responder.sv
// tb/tb_hyper_responder.sv - directed bench for hyper_responder acting as a HyperBus controller
module tb_hyper_responder;

  localparam int LAT = 22;

`ifdef HYPER_RESP_REG_EN
  localparam logic [15:0] EXP_ID0 = 16'h0C81;
  localparam logic [15:0] EXP_CR1 = 16'h0002;
  localparam logic [15:0] EXP_CR0 = 16'h8F1C;
`else
  localparam logic [15:0] EXP_ID0 = 16'h0000;
  localparam logic [15:0] EXP_CR1 = 16'h0000;
  localparam logic [15:0] EXP_CR0 = 16'h0000;
`endif

  logic       clk = 1'b0;
  logic       reset, dram_ck, dram_cs_l, dram_rst_l, dram_rwds_in;
  logic [7:0] dram_dq_in, dram_dq_out;
  logic       dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l, busy, proto_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        watch    = 1'b0;
  logic [31:0] rd_d;

  always #5 clk = ~clk;

  hyper_responder dut (
    .clk            (clk),
    .reset          (reset),
    .dram_ck        (dram_ck),
    .dram_cs_l      (dram_cs_l),
    .dram_rst_l     (dram_rst_l),
    .dram_dq_in     (dram_dq_in),
    .dram_dq_out    (dram_dq_out),
    .dram_dq_oe_l   (dram_dq_oe_l),
    .dram_rwds_in   (dram_rwds_in),
    .dram_rwds_out  (dram_rwds_out),
    .dram_rwds_oe_l (dram_rwds_oe_l),
    .busy           (busy),
    .proto_err      (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [47:0] make_ca(input logic rd, input logic rs, input logic [31:0] a);
    logic [47:0] ca;
    ca        = '0;
    ca[47]    = rd;
    ca[46]    = rs;
    ca[45]    = 1'b1;
    ca[44:16] = a[31:3];
    ca[2:0]   = a[2:0];
    return ca;
  endfunction

  task automatic bus_edge(input logic [7:0] dq, input logic rw);
    @(negedge clk);
    dram_dq_in   = dq;
    dram_rwds_in = rw;
    dram_ck      = ~dram_ck;
    @(posedge clk); #1;
  endtask

  task automatic cs_start();
    @(negedge clk);
    dram_cs_l = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cs_end();
    @(negedge clk);
    dram_cs_l = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_ca(input logic [47:0] ca);
    for (int i = 0; i < 6; i++) begin
      bus_edge(ca[47:40], 1'b0);
      ca = ca << 8;
      if (watch && i == 0) begin
        check("ca_rwds_oe", dram_rwds_oe_l, 0);
        check("ca_rwds_lat2x", dram_rwds_out, 1);
      end
    end
  endtask

  task automatic latency();
    for (int i = 1; i <= LAT; i++) begin
      bus_edge(8'h00, 1'b0);
      if (watch && i == 1)       check("lat_rwds_released", dram_rwds_oe_l, 1);
      if (watch && i == LAT - 1) check("edge27_dq_oe", dram_dq_oe_l, 1);
      if (watch && i == LAT) begin
        check("edge28_dq_oe", dram_dq_oe_l, 0);
        check("edge28_rwds", dram_rwds_out, 0);
      end
    end
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cs_start();
    send_ca(make_ca(1'b0, 1'b0, a));
    latency();
    for (int i = 3; i >= 0; i--) begin
      bus_edge(d[31:24], ~be[i]);
      d = d << 8;
    end
    check("wr_rwds_released", dram_rwds_oe_l, 1);
    cs_end();
  endtask

  task automatic hbus_read(input logic [31:0] a, input logic rs, input int nw, output logic [31:0] d);
    logic [7:0] hi;
    d = '0;
    cs_start();
    send_ca(make_ca(1'b1, rs, a));
    latency();
    for (int w = 0; w < nw; w++) begin
      bus_edge(8'h00, 1'b0);
      hi = dram_dq_out;
      check("rd_rwds_hi", dram_rwds_out, 1);
      if (watch && w == 0) check("edge29_first_byte", dram_dq_out, 8'hDE);
      bus_edge(8'h00, 1'b0);
      check("rd_rwds_lo", dram_rwds_out, 0);
      d = {d[15:0], hi, dram_dq_out};
    end
    cs_end();
    check("rd_end_dq_oe", dram_dq_oe_l, 1);
    check("rd_end_no_perr", proto_err, 0);
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [15:0] w);
    cs_start();
    send_ca(make_ca(1'b0, 1'b1, a));
    bus_edge(w[15:8], 1'b0);
    bus_edge(w[7:0], 1'b0);
    check("regwr_done_busy", busy, 1);
    cs_end();
    check("regwr_idle_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dram_ck = 1'b0; dram_cs_l = 1'b1; dram_rst_l = 1'b1;
    dram_dq_in = 8'h00; dram_rwds_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dq_out", dram_dq_out, 0);
    check("rst_dq_oe", dram_dq_oe_l, 1);
    check("rst_rwds_oe", dram_rwds_oe_l, 1);
    check("rst_busy", busy, 0);
    check("rst_perr", proto_err, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 0);

    // Full write then read, with edge-accurate latency checks on the read
    mem_write(32'h10, 32'hDEADBEEF, 4'hF);
    watch = 1'b1;
    hbus_read(32'h10, 1'b0, 2, rd_d);
    watch = 1'b0;
    check("rd_deadbeef", rd_d, 32'hDEADBEEF);

    // Byte masking
    mem_write(32'h20, 32'h11223344, 4'hF);
    mem_write(32'h20, 32'hAABBCCDD, 4'b0101);
    hbus_read(32'h20, 1'b0, 2, rd_d);
    check("rd_masked", rd_d, 32'h11BB33DD);

    // Address wrap on both write and read
    mem_write(32'h3FF, 32'hCAFEF00D, 4'hF);
    hbus_read(32'h3FF, 1'b0, 2, rd_d);
    check("rd_wrap", rd_d, 32'hCAFEF00D);
    hbus_read(32'h000, 1'b0, 1, rd_d);
    check("rd_addr0", rd_d, 32'h0000F00D);

    // CA phase cut short after 3 edges
    cs_start();
    bus_edge(8'h20, 1'b0);
    bus_edge(8'h00, 1'b0);
    bus_edge(8'h00, 1'b0);
    check("ca3_busy", busy, 1);
    cs_end();
    check("perr_pulse", proto_err, 1);
    check("perr_busy", busy, 0);
    @(posedge clk); #1;
    check("perr_one_cycle", proto_err, 0);
    hbus_read(32'h10, 1'b0, 2, rd_d);
    check("rd_after_perr", rd_d, 32'hDEADBEEF);

    // Device reset on the low-byte edge of a write: nothing committed
    cs_start();
    send_ca(make_ca(1'b0, 1'b0, 32'h10));
    latency();
    bus_edge(8'h55, 1'b0);
    @(negedge clk);
    dram_dq_in = 8'h66; dram_rwds_in = 1'b0; dram_ck = ~dram_ck; dram_rst_l = 1'b0;
    @(posedge clk); #1;
    check("rstl_busy", busy, 0);
    @(negedge clk); dram_rst_l = 1'b1;
    bus_edge(8'h77, 1'b0);
    bus_edge(8'h88, 1'b0);
    check("rstl_stays_idle", busy, 0);
    cs_end();
    hbus_read(32'h10, 1'b0, 2, rd_d);
    check("rd_after_rstl", rd_d, 32'hDEADBEEF);

    // Register space
    hbus_read(32'h000, 1'b1, 1, rd_d);
    check("reg_id0", rd_d, {16'h0, EXP_ID0});
    hbus_read(32'h001, 1'b1, 1, rd_d);
    check("reg_id1", rd_d, 32'h0);
    hbus_read(32'h801, 1'b1, 1, rd_d);
    check("reg_cr1_rst", rd_d, {16'h0, EXP_CR1});
    reg_write(32'h800, 16'h8F1C);
    hbus_read(32'h800, 1'b1, 1, rd_d);
    check("reg_cr0", rd_d, {16'h0, EXP_CR0});
    hbus_read(32'h000, 1'b0, 1, rd_d);
    check("regwr_mem_untouched", rd_d, 32'h0000F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
